// File: rtl/shared_tlb_ctrl_pkg.sv
// Shared types for the shared-TLB controller: state encoding, latched request/response, SV39 PTE.
// SHARED_TLB_PERF_CNT_EN (in the top) uses the saturating increment below.
package shared_tlb_ctrl_pkg;

  localparam int unsigned VLEN         = 64;
  localparam int unsigned MaxAsidWidth = 16;
  localparam int unsigned PerfCntWidth = 32;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWalkReq,
    StWalkWait,
    StRelookup,
    StResp
  } stlb_state_e;

  typedef struct packed {
    logic [VLEN-1:0]         vaddr;
    logic [MaxAsidWidth-1:0] asid;
    logic                    is_dtlb;
  } stlb_req_t;

  typedef struct packed {
    pte_t content;
    logic is_2M;
    logic is_1G;
    logic error;
  } stlb_rsp_t;

  function automatic logic [PerfCntWidth-1:0] sat_inc(input logic [PerfCntWidth-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/shared_tlb_ctrl_rr_arb_2.sv
// Two-way round-robin arbiter; bit 0 = ITLB, bit 1 = DTLB. A tie goes to the side not granted last.
module shared_tlb_ctrl_rr_arb_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = DTLB was granted last; reset value makes DTLB win the first tie.
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    last_d = last_q;
    if (|gnt_o) last_d = gnt_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/shared_tlb_ctrl.sv
// Sequences the shared SV39 TLB between ITLB and DTLB misses: arbitrate, look up, walk, re-look-up.
// Optional SHARED_TLB_PERF_CNT_EN adds saturating LOOKUP hit/miss counters.
module shared_tlb_ctrl
  import shared_tlb_ctrl_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  itlb_req_i,
  input  logic [VLEN-1:0]       itlb_vaddr_i,
  output logic                  itlb_gnt_o,
  input  logic                  dtlb_req_i,
  input  logic [VLEN-1:0]       dtlb_vaddr_i,
  output logic                  dtlb_gnt_o,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_is_dtlb_o,
  output pte_t                  rsp_content_o,
  output logic                  rsp_is_2M_o,
  output logic                  rsp_is_1G_o,
  output logic                  rsp_error_o,
`ifdef SHARED_TLB_PERF_CNT_EN
  output logic [PerfCntWidth-1:0] perf_hit_o,
  output logic [PerfCntWidth-1:0] perf_miss_o,
`endif
  output logic                  stlb_access_o,
  output logic [VLEN-1:0]       stlb_vaddr_o,
  output logic [ASID_WIDTH-1:0] stlb_asid_o,
  input  logic                  stlb_hit_i,
  input  pte_t                  stlb_content_i,
  input  logic                  stlb_is_2M_i,
  input  logic                  stlb_is_1G_i,
  output logic                  ptw_req_o,
  output logic [VLEN-1:0]       ptw_vaddr_o,
  input  logic                  ptw_gnt_i,
  input  logic                  ptw_done_i,
  input  logic                  ptw_error_i
);

  stlb_state_e state_q, state_d;
  stlb_req_t   req_q, req_d;
  stlb_rsp_t   rsp_q, rsp_d;
  logic        drop_q, drop_d;
  logic [1:0]  arb_gnt;
  logic        arb_en;
  logic        unused_asid;

  assign arb_en      = (state_q == StIdle) && !flush_i && !rst_i;
  assign unused_asid = ^req_q.asid;

  shared_tlb_ctrl_rr_arb_2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (arb_en),
    .req_i ({dtlb_req_i, itlb_req_i}),
    .gnt_o (arb_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      req_q   <= '0;
      rsp_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          state_d                     = StLookup;
          req_d.vaddr                 = arb_gnt[1] ? dtlb_vaddr_i : itlb_vaddr_i;
          req_d.asid                  = '0;
          req_d.asid[ASID_WIDTH-1:0]  = asid_i;
          req_d.is_dtlb               = arb_gnt[1];
          rsp_d                       = '0;
          drop_d                      = 1'b0;
        end
      end
      StLookup, StRelookup: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (stlb_hit_i) begin
          rsp_d.content = stlb_content_i;
          rsp_d.is_2M   = stlb_is_2M_i;
          rsp_d.is_1G   = stlb_is_1G_i;
          rsp_d.error   = 1'b0;
          state_d       = StResp;
        end else if (state_q == StLookup) begin
          state_d = StWalkReq;
        end else begin
          // Refill did not land in the shared TLB: report it rather than loop.
          rsp_d.error = 1'b1;
          state_d     = StResp;
        end
      end
      StWalkReq: begin
        if (flush_i)        state_d = StIdle;
        else if (ptw_gnt_i) state_d = StWalkWait;
      end
      StWalkWait: begin
        if (flush_i) drop_d = 1'b1;
        if (ptw_done_i) begin
          if (drop_q || flush_i) begin
            state_d = StIdle;
            drop_d  = 1'b0;
          end else if (ptw_error_i) begin
            rsp_d.error = 1'b1;
            state_d     = StResp;
          end else begin
            state_d = StRelookup;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    itlb_gnt_o    = arb_gnt[0];
    dtlb_gnt_o    = arb_gnt[1];
    stlb_access_o = ((state_q == StLookup) || (state_q == StRelookup)) && !flush_i;
    stlb_vaddr_o  = req_q.vaddr;
    stlb_asid_o   = req_q.asid[ASID_WIDTH-1:0];
    ptw_req_o     = (state_q == StWalkReq) && !flush_i;
    ptw_vaddr_o   = req_q.vaddr;
    rsp_valid_o   = (state_q == StResp) && !flush_i;
    rsp_is_dtlb_o = req_q.is_dtlb;
    rsp_content_o = rsp_q.content;
    rsp_is_2M_o   = rsp_q.is_2M;
    rsp_is_1G_o   = rsp_q.is_1G;
    rsp_error_o   = rsp_q.error;
  end

`ifdef SHARED_TLB_PERF_CNT_EN
  logic [PerfCntWidth-1:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;

  // Only first lookups count; the post-walk re-lookup is excluded.
  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    if ((state_q == StLookup) && !flush_i) begin
      if (stlb_hit_i) perf_hit_d  = sat_inc(perf_hit_q);
      else            perf_miss_d = sat_inc(perf_miss_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_shared_tlb_ctrl.sv
// Directed bench for shared_tlb_ctrl; the shared TLB is modelled by hit_mode and a vaddr->PTE function.
module tb_shared_tlb_ctrl;
  import shared_tlb_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst_i, flush_i;
  logic            itlb_req_i, dtlb_req_i, itlb_gnt_o, dtlb_gnt_o;
  logic [VLEN-1:0] itlb_vaddr_i, dtlb_vaddr_i;
  logic [0:0]      asid_i, stlb_asid_o;
  logic            rsp_valid_o, rsp_is_dtlb_o, rsp_is_2M_o, rsp_is_1G_o, rsp_error_o;
  pte_t            rsp_content_o, stlb_content_i;
  logic            stlb_access_o, stlb_hit_i, stlb_is_2M_i, stlb_is_1G_i;
  logic [VLEN-1:0] stlb_vaddr_o, ptw_vaddr_o;
  logic            ptw_req_o, ptw_gnt_i, ptw_done_i, ptw_error_i;
`ifdef SHARED_TLB_PERF_CNT_EN
  logic [31:0]     perf_hit_o, perf_miss_o;
`endif

  int checks = 0;
  int failures = 0;
  logic hit_mode, tb_2m, tb_1g;

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_pte(input logic [63:0] va);
    return {10'h0, va[55:12] ^ 44'h000_00AB_CDEF, 8'hCF};
  endfunction

  always_comb begin
    stlb_hit_i     = hit_mode;
    stlb_content_i = mk_pte(stlb_vaddr_o);
    stlb_is_2M_i   = tb_2m;
    stlb_is_1G_i   = tb_1g;
  end

  shared_tlb_ctrl #(.ASID_WIDTH(1)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .itlb_req_i     (itlb_req_i),
    .itlb_vaddr_i   (itlb_vaddr_i),
    .itlb_gnt_o     (itlb_gnt_o),
    .dtlb_req_i     (dtlb_req_i),
    .dtlb_vaddr_i   (dtlb_vaddr_i),
    .dtlb_gnt_o     (dtlb_gnt_o),
    .asid_i         (asid_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_is_dtlb_o  (rsp_is_dtlb_o),
    .rsp_content_o  (rsp_content_o),
    .rsp_is_2M_o    (rsp_is_2M_o),
    .rsp_is_1G_o    (rsp_is_1G_o),
    .rsp_error_o    (rsp_error_o),
`ifdef SHARED_TLB_PERF_CNT_EN
    .perf_hit_o     (perf_hit_o),
    .perf_miss_o    (perf_miss_o),
`endif
    .stlb_access_o  (stlb_access_o),
    .stlb_vaddr_o   (stlb_vaddr_o),
    .stlb_asid_o    (stlb_asid_o),
    .stlb_hit_i     (stlb_hit_i),
    .stlb_content_i (stlb_content_i),
    .stlb_is_2M_i   (stlb_is_2M_i),
    .stlb_is_1G_i   (stlb_is_1G_i),
    .ptw_req_o      (ptw_req_o),
    .ptw_vaddr_o    (ptw_vaddr_o),
    .ptw_gnt_i      (ptw_gnt_i),
    .ptw_done_i     (ptw_done_i),
    .ptw_error_i    (ptw_error_i)
  );

  // Moves to 1 time unit after the next rising edge; callers then drive and sample at +1 more.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    itlb_vaddr_i = '0; dtlb_vaddr_i = '0; asid_i = 1'b0;
    ptw_gnt_i = 1'b0; ptw_done_i = 1'b0; ptw_error_i = 1'b0;
    hit_mode = 1'b0; tb_2m = 1'b0; tb_1g = 1'b0;
    tick(); tick();
    itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
    #1;
    checks++; if ({itlb_gnt_o, dtlb_gnt_o} !== 2'b00) begin failures++;
      $display("FAIL reset_gnt: got %b want 00", {itlb_gnt_o, dtlb_gnt_o}); end
    checks++; if ({rsp_valid_o, stlb_access_o, ptw_req_o, rsp_error_o} !== 4'b0) begin failures++;
      $display("FAIL reset_strobes: got %b want 0000",
               {rsp_valid_o, stlb_access_o, ptw_req_o, rsp_error_o}); end
    checks++; if (rsp_content_o !== 64'h0) begin failures++;
      $display("FAIL reset_content: got %h want 0", rsp_content_o); end
    tick();
    rst_i = 1'b0; itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
  endtask

  task automatic test_itlb_hit();
    tick();
    itlb_req_i = 1'b1; itlb_vaddr_i = 64'h8000_1000; asid_i = 1'b1; hit_mode = 1'b1;
    #1;
    checks++; if ({itlb_gnt_o, dtlb_gnt_o} !== 2'b10) begin failures++;
      $display("FAIL hit_gnt: got i/d=%b want 10", {itlb_gnt_o, dtlb_gnt_o}); end
    tick();
    itlb_req_i = 1'b0; asid_i = 1'b0;
    #1;
    checks++; if ({stlb_access_o, rsp_valid_o} !== 2'b10) begin failures++;
      $display("FAIL hit_lookup: got acc/rsp=%b want 10", {stlb_access_o, rsp_valid_o}); end
    checks++; if (stlb_vaddr_o !== 64'h8000_1000 || stlb_asid_o !== 1'b1) begin failures++;
      $display("FAIL hit_lookup_addr: got %h/%b want 80001000/1", stlb_vaddr_o, stlb_asid_o); end
    tick(); #1;
    checks++; if ({rsp_valid_o, rsp_is_dtlb_o, rsp_error_o} !== 3'b100) begin failures++;
      $display("FAIL hit_rsp: got v/d/e=%b want 100", {rsp_valid_o, rsp_is_dtlb_o, rsp_error_o}); end
    checks++; if (rsp_content_o !== mk_pte(64'h8000_1000)) begin failures++;
      $display("FAIL hit_content: got %h want %h", rsp_content_o, mk_pte(64'h8000_1000)); end
    tick(); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++;
      $display("FAIL hit_rsp_pulse: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic            exp_d;
    logic [VLEN-1:0] exp_va;
    tick();
    itlb_req_i = 1'b1; itlb_vaddr_i = 64'h1000;
    dtlb_req_i = 1'b1; dtlb_vaddr_i = 64'h2000_0000; hit_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_d  = (i % 2 == 0);
      exp_va = exp_d ? dtlb_vaddr_i : itlb_vaddr_i;
      checks++; if ({dtlb_gnt_o, itlb_gnt_o} !== {exp_d, !exp_d}) begin failures++;
        $display("FAIL b2b_gnt[%0d]: got d/i=%b want %b", i, {dtlb_gnt_o, itlb_gnt_o},
                 {exp_d, !exp_d}); end
      tick();
      if (exp_d) dtlb_vaddr_i += 64'h1000;
      else       itlb_vaddr_i += 64'h1000;
      #1;
      checks++; if (stlb_vaddr_o !== exp_va) begin failures++;
        $display("FAIL b2b_vaddr[%0d]: got %h want %h", i, stlb_vaddr_o, exp_va); end
      tick(); #1;
      checks++; if ({rsp_valid_o, rsp_is_dtlb_o} !== {1'b1, exp_d}) begin failures++;
        $display("FAIL b2b_rsp[%0d]: got v/d=%b want 1%b", i, {rsp_valid_o, rsp_is_dtlb_o},
                 exp_d); end
      checks++; if (rsp_content_o !== mk_pte(exp_va)) begin failures++;
        $display("FAIL b2b_content[%0d]: got %h want %h", i, rsp_content_o, mk_pte(exp_va)); end
      if (i == 3) begin itlb_req_i = 1'b0; dtlb_req_i = 1'b0; end
      tick();
    end
  endtask

  task automatic test_dtlb_miss_walk();
    int ptw_cnt = 0;
    int quiet_bad = 0;
    tick();
    dtlb_req_i = 1'b1; dtlb_vaddr_i = 64'h3F_C000_5000; hit_mode = 1'b0;
    #1;
    checks++; if (dtlb_gnt_o !== 1'b1) begin failures++;
      $display("FAIL miss_gnt: got %b want 1", dtlb_gnt_o); end
    tick();
    dtlb_req_i = 1'b0;
    #1;
    checks++; if ({stlb_access_o, rsp_valid_o} !== 2'b10) begin failures++;
      $display("FAIL miss_lookup: got acc/rsp=%b want 10", {stlb_access_o, rsp_valid_o}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      ptw_gnt_i = (k == 2);
      #1;
      if (ptw_req_o) ptw_cnt++;
      if (k == 0) begin
        checks++; if (ptw_vaddr_o !== 64'h3F_C000_5000) begin failures++;
          $display("FAIL miss_ptw_vaddr: got %h want 3fc0005000", ptw_vaddr_o); end
      end
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      ptw_gnt_i = 1'b0;
      #1;
      if (ptw_req_o) ptw_cnt++;
      if (rsp_valid_o || stlb_access_o) quiet_bad++;
    end
    tick();
    ptw_done_i = 1'b1; hit_mode = 1'b1; tb_2m = 1'b1;
    #1;
    if (ptw_req_o) ptw_cnt++;
    if (rsp_valid_o || stlb_access_o) quiet_bad++;
    checks++; if (quiet_bad !== 0) begin failures++;
      $display("FAIL miss_quiet: got %0d busy cycles want 0", quiet_bad); end
    tick();
    ptw_done_i = 1'b0;
    #1;
    checks++; if (stlb_access_o !== 1'b1 || stlb_vaddr_o !== 64'h3F_C000_5000) begin failures++;
      $display("FAIL miss_relookup: got acc=%b va=%h want 1/3fc0005000", stlb_access_o,
               stlb_vaddr_o); end
    tick(); #1;
    checks++; if ({rsp_valid_o, rsp_is_dtlb_o, rsp_is_2M_o, rsp_is_1G_o, rsp_error_o} !== 5'b11100)
      begin failures++;
      $display("FAIL miss_rsp: got v/d/2M/1G/e=%b want 11100",
               {rsp_valid_o, rsp_is_dtlb_o, rsp_is_2M_o, rsp_is_1G_o, rsp_error_o}); end
    checks++; if (rsp_content_o !== mk_pte(64'h3F_C000_5000)) begin failures++;
      $display("FAIL miss_content: got %h want %h", rsp_content_o, mk_pte(64'h3F_C000_5000)); end
    checks++; if (ptw_cnt !== 3) begin failures++;
      $display("FAIL miss_ptw_req_cycles: got %0d want 3", ptw_cnt); end
    tick();
    tb_2m = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++;
      $display("FAIL miss_rsp_pulse: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_walk_error();
    tick();
    itlb_req_i = 1'b1; itlb_vaddr_i = 64'h7000; hit_mode = 1'b0;
    #1;
    checks++; if (itlb_gnt_o !== 1'b1) begin failures++;
      $display("FAIL err_gnt: got %b want 1", itlb_gnt_o); end
    tick();
    itlb_req_i = 1'b0;
    tick();
    ptw_gnt_i = 1'b1;
    #1;
    checks++; if (ptw_req_o !== 1'b1) begin failures++;
      $display("FAIL err_ptw_req: got %b want 1", ptw_req_o); end
    tick();
    ptw_gnt_i = 1'b0; ptw_done_i = 1'b1; ptw_error_i = 1'b1;
    tick();
    ptw_done_i = 1'b0; ptw_error_i = 1'b0;
    #1;
    checks++; if ({rsp_valid_o, rsp_error_o, rsp_is_dtlb_o, stlb_access_o} !== 4'b1100) begin
      failures++;
      $display("FAIL err_rsp: got v/e/d/acc=%b want 1100",
               {rsp_valid_o, rsp_error_o, rsp_is_dtlb_o, stlb_access_o}); end
    tick(); #1;
    checks++; if ({rsp_valid_o, stlb_access_o} !== 2'b00) begin failures++;
      $display("FAIL err_after: got v/acc=%b want 00", {rsp_valid_o, stlb_access_o}); end
  endtask

  task automatic test_flush_walk_wait();
    int bad = 0;
    tick();
    dtlb_req_i = 1'b1; dtlb_vaddr_i = 64'h9000; hit_mode = 1'b0;
    tick();
    dtlb_req_i = 1'b0;
    tick();
    ptw_gnt_i = 1'b1;
    tick();
    ptw_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; itlb_req_i = 1'b1; itlb_vaddr_i = 64'hA000;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (rsp_valid_o || itlb_gnt_o) bad++;
      tick();
    end
    ptw_done_i = 1'b1; hit_mode = 1'b1;
    #1;
    if (rsp_valid_o || itlb_gnt_o) bad++;
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL flush_ww_quiet: got %0d bad cycles want 0", bad); end
    tick();
    ptw_done_i = 1'b0;
    #1;
    checks++; if ({itlb_gnt_o, rsp_valid_o} !== 2'b10) begin failures++;
      $display("FAIL flush_ww_regnt: got gnt/rsp=%b want 10", {itlb_gnt_o, rsp_valid_o}); end
    tick();
    itlb_req_i = 1'b0;
    #1;
    checks++; if (stlb_access_o !== 1'b1 || stlb_vaddr_o !== 64'hA000) begin failures++;
      $display("FAIL flush_ww_lookup: got acc=%b va=%h want 1/a000", stlb_access_o,
               stlb_vaddr_o); end
    tick(); #1;
    checks++; if ({rsp_valid_o, rsp_is_dtlb_o} !== 2'b10 || rsp_content_o !== mk_pte(64'hA000))
      begin failures++;
      $display("FAIL flush_ww_rsp: got v/d=%b c=%h want 10 %h", {rsp_valid_o, rsp_is_dtlb_o},
               rsp_content_o, mk_pte(64'hA000)); end
    tick();
  endtask

  task automatic test_flush_lookup();
    tick();
    itlb_req_i = 1'b1; itlb_vaddr_i = 64'hB000; flush_i = 1'b1; hit_mode = 1'b1;
    #1;
    checks++; if (itlb_gnt_o !== 1'b0) begin failures++;
      $display("FAIL flush_idle_gnt: got %b want 0", itlb_gnt_o); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if (itlb_gnt_o !== 1'b1) begin failures++;
      $display("FAIL flush_idle_regnt: got %b want 1", itlb_gnt_o); end
    tick();
    itlb_req_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; dtlb_req_i = 1'b1; dtlb_vaddr_i = 64'hC000;
    #1;
    checks++; if ({rsp_valid_o, dtlb_gnt_o} !== 2'b01) begin failures++;
      $display("FAIL flush_lookup: got rsp/gnt=%b want 01", {rsp_valid_o, dtlb_gnt_o}); end
    tick();
    dtlb_req_i = 1'b0;
    tick(); #1;
    checks++; if ({rsp_valid_o, rsp_is_dtlb_o} !== 2'b11 || rsp_content_o !== mk_pte(64'hC000))
      begin failures++;
      $display("FAIL flush_lookup_rsp: got v/d=%b c=%h want 11 %h",
               {rsp_valid_o, rsp_is_dtlb_o}, rsp_content_o, mk_pte(64'hC000)); end
    tick();
  endtask

`ifdef SHARED_TLB_PERF_CNT_EN
  task automatic test_perf();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick(); itlb_req_i = 1'b1; itlb_vaddr_i = 64'h1_0000 + 64'(n) * 64'h1000; hit_mode = 1'b1;
      tick(); itlb_req_i = 1'b0;
      tick(); tick();
    end
    for (int n = 0; n < 2; n++) begin
      tick(); dtlb_req_i = 1'b1; dtlb_vaddr_i = 64'h2_0000; hit_mode = 1'b0;
      tick(); dtlb_req_i = 1'b0;
      tick(); ptw_gnt_i = 1'b1;
      tick(); ptw_gnt_i = 1'b0; ptw_done_i = 1'b1; ptw_error_i = 1'b1;
      tick(); ptw_done_i = 1'b0; ptw_error_i = 1'b0;
      tick();
    end
    #1;
    checks++; if (perf_hit_o !== 32'd3 || perf_miss_o !== 32'd2) begin failures++;
      $display("FAIL perf_counts: got hit=%0d miss=%0d want 3/2", perf_hit_o, perf_miss_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (perf_hit_o !== 32'd0 || perf_miss_o !== 32'd0) begin failures++;
      $display("FAIL perf_reset: got hit=%0d miss=%0d want 0/0", perf_hit_o, perf_miss_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_itlb_hit();
    test_back_to_back();
    test_dtlb_miss_walk();
    test_walk_error();
    test_flush_walk_wait();
    test_flush_lookup();
`ifdef SHARED_TLB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
